// File: rtl/downcounter_game_pkg.sv
// Shared game definitions: FSM states, BCD digit type and digit clamp.
package downcounter_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } game_state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // Out-of-range digits (A..F) saturate to 9.
   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/downcounter_game_if.sv
// Control/status bundle of the countdown timer; master drives commands, slave reports digits.
interface downcounter_game_if;
   import downcounter_game_pkg::*;

   logic load;
   bcd_t load_value1;
   bcd_t load_value2;
   logic start;
   logic pause;
   logic clear;
   bcd_t value1;
   bcd_t value2;
   logic running;
   logic expired;
   logic tick;
   logic expire_pulse;

   modport master (
      output load, load_value1, load_value2, start, pause, clear,
      input  value1, value2, running, expired, tick, expire_pulse
   );

   modport slave (
      input  load, load_value1, load_value2, start, pause, clear,
      output value1, value2, running, expired, tick, expire_pulse
   );

endinterface

// File: rtl/downcounter_game_tick_prescaler.sv
// Free-running prescaler counting 0..TICK_DIV-1 while enabled; tc flags the terminal cycle.
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000,
   parameter int CNT_W    = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   assign tc = en && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= tc ? '0 : cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/downcounter_game.sv
// Two-digit BCD countdown timer with pause/resume/clear and expiry pulse.
// Optional GAME_TIMER_AUTORELOAD_EN: reload the start value on reaching 00 instead of expiring.
module downcounter_game
   import downcounter_game_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int CNT_W    = 27
) (
   input  logic               clk,
   input  logic               rst_n,
   downcounter_game_if.slave  bus
);

   game_state_t state_reg;
   bcd_t        value1_reg;
   bcd_t        value2_reg;
   bcd_t        reload1_reg;
   bcd_t        reload2_reg;
   logic        running_reg;
   logic        expired_reg;
   logic        tick_reg;
   logic        expire_pulse_reg;

   logic        tc;
   logic        prescale_en;
   bcd_t        dec1_next;
   bcd_t        dec2_next;
   bcd_t        load1_next;
   bcd_t        load2_next;
   logic        dec_zero;
   logic        count_zero;
   logic        reload_ok;

   assign prescale_en = (state_reg == ST_RUN) && !bus.clear;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (prescale_en),
      .clr   (bus.clear),
      .tc    (tc)
   );

   // BCD decrement with borrow from the tens digit.
   always_comb begin
      dec1_next = value1_reg;
      dec2_next = value2_reg;
      if (value1_reg != '0) begin
         dec1_next = value1_reg - 1'b1;
      end else begin
         dec1_next = BCD_MAX;
         dec2_next = value2_reg - 1'b1;
      end
   end

   assign dec_zero   = (dec1_next == '0) && (dec2_next == '0);
   assign count_zero = (value1_reg == '0) && (value2_reg == '0);
   assign load1_next = bcd_clamp(bus.load_value1);
   assign load2_next = bcd_clamp(bus.load_value2);

`ifdef GAME_TIMER_AUTORELOAD_EN
   assign reload_ok = (reload1_reg != '0) || (reload2_reg != '0);
`else
   assign reload_ok = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         value1_reg       <= '0;
         value2_reg       <= '0;
         reload1_reg      <= '0;
         reload2_reg      <= '0;
         running_reg      <= 1'b0;
         expired_reg      <= 1'b0;
         tick_reg         <= 1'b0;
         expire_pulse_reg <= 1'b0;
      end else begin
         tick_reg         <= 1'b0;
         expire_pulse_reg <= 1'b0;
         if (bus.clear) begin
            state_reg   <= ST_IDLE;
            value1_reg  <= '0;
            value2_reg  <= '0;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE, ST_EXPIRED: begin
                  if (bus.load) begin
                     value1_reg  <= load1_next;
                     value2_reg  <= load2_next;
                     reload1_reg <= load1_next;
                     reload2_reg <= load2_next;
                     state_reg   <= ST_IDLE;
                     expired_reg <= 1'b0;
                  end else if (state_reg == ST_IDLE && bus.start && !count_zero) begin
                     state_reg   <= ST_RUN;
                     running_reg <= 1'b1;
                  end
               end
               ST_PAUSE: begin
                  if (bus.start) begin
                     state_reg   <= ST_RUN;
                     running_reg <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (tc && dec_zero && !reload_ok) begin
                     tick_reg         <= 1'b1;
                     expire_pulse_reg <= 1'b1;
                     value1_reg       <= '0;
                     value2_reg       <= '0;
                     state_reg        <= ST_EXPIRED;
                     running_reg      <= 1'b0;
                     expired_reg      <= 1'b1;
                  end else begin
                     if (tc) begin
                        tick_reg         <= 1'b1;
                        expire_pulse_reg <= dec_zero;
                        value1_reg       <= dec_zero ? reload1_reg : dec1_next;
                        value2_reg       <= dec_zero ? reload2_reg : dec2_next;
                     end
                     // A tick in the same cycle as pause still lands before freezing.
                     if (bus.pause) begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_reg   <= ST_IDLE;
                  running_reg <= 1'b0;
                  expired_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.value1       = value1_reg;
   assign bus.value2       = value2_reg;
   assign bus.running      = running_reg;
   assign bus.expired      = expired_reg;
   assign bus.tick         = tick_reg;
   assign bus.expire_pulse = expire_pulse_reg;

endmodule

// File: tb/tb_downcounter_game.sv
// Scoreboard bench for downcounter_game: integer-count reference model, directed + random stimulus.
module tb_downcounter_game;

   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 3;
`ifdef GAME_TIMER_AUTORELOAD_EN
   localparam bit AUTORELOAD = 1'b1;
`else
   localparam bit AUTORELOAD = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_EXP   = 3;

   typedef struct {
      int n;
      bit run;
      bit exp;
      bit tick;
      bit ep;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];

   int m_n, m_reload, m_phase, m_mode;

   downcounter_game_if bus();

   downcounter_game #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int clamp9(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   task automatic model_reset();
      m_n = 0; m_reload = 0; m_phase = 0; m_mode = M_IDLE;
   endtask

   task automatic model_step(input bit clr, input bit ld, input int lv1, input int lv2,
                             input bit st, input bit ps, output exp_t e);
      bit tk = 1'b0;
      bit ep = 1'b0;
      if (clr) begin
         m_mode = M_IDLE; m_n = 0; m_phase = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (ld) begin
                  m_n = 10 * clamp9(lv2) + clamp9(lv1); m_reload = m_n;
               end else if (st && m_n != 0) begin
                  m_mode = M_RUN;
               end
            end
            M_EXP: begin
               if (ld) begin
                  m_n = 10 * clamp9(lv2) + clamp9(lv1); m_reload = m_n; m_mode = M_IDLE;
               end
            end
            M_PAUSE: if (st) m_mode = M_RUN;
            default: begin
               m_phase++;
               if (m_phase == TICK_DIV) begin
                  m_phase = 0; tk = 1'b1; m_n--;
                  if (m_n == 0) begin
                     ep = 1'b1;
                     if (AUTORELOAD && m_reload != 0) m_n = m_reload;
                     else m_mode = M_EXP;
                  end
               end
               if (m_mode == M_RUN && ps) m_mode = M_PAUSE;
            end
         endcase
      end
      e.n = m_n; e.run = (m_mode == M_RUN); e.exp = (m_mode == M_EXP);
      e.tick = tk; e.ep = ep;
   endtask

   task automatic do_cycle(input bit clr, input bit ld, input int lv1, input int lv2,
                           input bit st, input bit ps);
      exp_t e;
      bus.clear = clr; bus.load = ld; bus.load_value1 = 4'(lv1); bus.load_value2 = 4'(lv2);
      bus.start = st; bus.pause = ps;
      model_step(clr, ld, lv1, lv2, st, ps, e);
      @(posedge clk);
      sb_q.push_back(e);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string name);
      total++;
      if (bus.value1 !== 4'd0 || bus.value2 !== 4'd0 || bus.running !== 1'b0 ||
          bus.expired !== 1'b0 || bus.tick !== 1'b0 || bus.expire_pulse !== 1'b0) begin
         bad++;
         $display("FAIL %s: got v=%0d%0d run=%0b exp=%0b tick=%0b ep=%0b, want all zero",
                  name, bus.value2, bus.value1, bus.running, bus.expired, bus.tick, bus.expire_pulse);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (bus.value1 !== 4'(e.n % 10) || bus.value2 !== 4'(e.n / 10) ||
                bus.running !== e.run || bus.expired !== e.exp ||
                bus.tick !== e.tick || bus.expire_pulse !== e.ep) begin
               bad++;
               $display("FAIL cycle_check t=%0t: got v=%0d%0d run=%0b exp=%0b tick=%0b ep=%0b, want v=%02d run=%0b exp=%0b tick=%0b ep=%0b",
                        $time, bus.value2, bus.value1, bus.running, bus.expired, bus.tick,
                        bus.expire_pulse, e.n, e.run, e.exp, e.tick, e.ep);
            end else if (e.tick) begin
               $display("t=%0t tick -> value %02d expire_pulse=%0b", $time, e.n, e.ep);
            end
         end
      end
   end

   initial begin : driver
      bus.clear = 1'b0; bus.load = 1'b0; bus.load_value1 = '0; bus.load_value2 = '0;
      bus.start = 1'b0; bus.pause = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_zero("reset_state");
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 12 -> 11 -> 10 -> 09 (borrow) and onward
      do_cycle(1'b0, 1'b1, 2, 1, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(18);
      do_cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

      // 01 -> 00 expiry
      do_cycle(1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(6);

      // pause / resume from 05
      do_cycle(1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(5);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      idle(20);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(4);

      // clamp, load ignored while running, clear in RUN, start at 00
      do_cycle(1'b0, 1'b1, 15, 12, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(3);
      do_cycle(1'b0, 1'b1, 3, 3, 1'b0, 1'b0);
      idle(2);
      do_cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(2);

      // asynchronous reset mid-run at 07
      do_cycle(1'b0, 1'b1, 7, 0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(6);
      #6 rst_n = 1'b0;
      #1 check_zero("midrun_reset");
      model_reset();
      @(posedge clk);
      #1 check_zero("reset_held");
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 03 run to the end (reload sequence when auto-reload is built in)
      do_cycle(1'b0, 1'b1, 3, 0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      idle(16);

      for (int i = 0; i < 600; i++) begin
         do_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
